// File: rtl/expr_pkg.sv
// Shared definitions for the expression evaluator: FSM state encoding,
// ASCII character constants and character-class helpers.
// Combinational only; no latency or flow control of its own.
package expr_pkg;

    typedef enum logic [2:0] {
        S_START   = 3'd0,
        S_OPND    = 3'd1,
        S_OPER    = 3'd2,
        S_LPAR    = 3'd3,
        S_IN_OPND = 3'd4,
        S_IN_OPER = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    localparam logic [7:0] CH_0    = 8'h30;  // '0'
    localparam logic [7:0] CH_9    = 8'h39;  // '9'
    localparam logic [7:0] CH_PLUS = 8'h2B;  // '+'
    localparam logic [7:0] CH_STAR = 8'h2A;  // '*'
    localparam logic [7:0] CH_LPAR = 8'h28;  // '('
    localparam logic [7:0] CH_RPAR = 8'h29;  // ')'

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == CH_PLUS) || (c == CH_STAR);
    endfunction

endpackage

// File: rtl/expr_acc.sv
// One sum/product accumulator level (sum, prod) for the evaluator.
// Latency: state updates on the next edge; sum_nxt/prod_nxt expose the pending values combinationally.
// Backpressure: none, every asserted control is applied in the cycle it is seen.
//
// Ports: clk, clr_n (async active-low); init / opnd (with val) / plus controls,
// at most one active per cycle (init wins, then opnd, then plus);
// sum, prod registered state; sum_nxt, prod_nxt next-state values;
// ovf: this cycle's operation exceeded W bits (only built with EXPR_EVAL_OVF_EN).
module expr_acc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         init,
    input  logic         opnd,
    input  logic [W-1:0] val,
    input  logic         plus,
    output logic [W-1:0] sum,
    output logic [W-1:0] prod,
    output logic [W-1:0] sum_nxt,
    output logic [W-1:0] prod_nxt,
    output logic         ovf
);

    logic [W-1:0] mul_w;
    logic [W-1:0] add_w;

`ifdef EXPR_EVAL_OVF_EN
    logic [2*W-1:0] mul_full;
    logic [W:0]     add_full;

    assign mul_full = (2*W)'(prod) * (2*W)'(val);
    assign add_full = (W+1)'(sum) + (W+1)'(prod);
    assign mul_w    = mul_full[W-1:0];
    assign add_w    = add_full[W-1:0];
    // Only the operation actually being applied can flag overflow.
    assign ovf      = !init && ((opnd && (|mul_full[2*W-1:W])) ||
                                (!opnd && plus && add_full[W]));
`else
    assign mul_w = prod * val;
    assign add_w = sum + prod;
    assign ovf   = 1'b0;
`endif

    always_comb begin
        sum_nxt  = sum;
        prod_nxt = prod;
        if (init) begin
            sum_nxt  = '0;
            prod_nxt = W'(1);
        end else if (opnd) begin
            prod_nxt = mul_w;
        end else if (plus) begin
            // Close the current product term into the running sum.
            sum_nxt  = add_w;
            prod_nxt = W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sum  <= '0;
            prod <= W'(1);
        end else begin
            sum  <= sum_nxt;
            prod <= prod_nxt;
        end
    end

endmodule

// File: rtl/expr_eval.sv
// Evaluates the integer value of a '+'/'*' expression stream (one level of parentheses).
// Latency: 1 cycle, a character accepted at edge n shows in the outputs after edge n.
// Backpressure: none, every character with in_valid high is consumed.
//
// Ports: clk, clr_n (async active-low); in / in_valid character input;
// result / result_valid value of the current complete prefix; err sticky grammar
// error; ovf sticky arithmetic overflow, built only when EXPR_EVAL_OVF_EN is
// defined (tied to 0 otherwise).
module expr_eval
    import expr_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         err,
    output logic         ovf
);

    state_t       state;
    state_t       nxt;

    logic         c_digit;
    logic         c_op;
    logic         c_plus;
    logic [W-1:0] dval;

    // Accumulator controls
    logic         o_opnd, o_plus;
    logic         i_init, i_opnd, i_plus;
    logic [W-1:0] o_val;
    logic         dig_app;    // a digit is being applied as an operand
    logic         rpar_app;   // ')' folds the inner value into the outer level

    logic [W-1:0] o_sum, o_prod, o_sum_nxt, o_prod_nxt;
    logic [W-1:0] i_sum, i_prod, i_sum_nxt, i_prod_nxt;
    logic         o_ovf, i_ovf;

    logic [W:0]   rpar_full;
    logic [W:0]   res_full;

    assign c_digit = is_digit(in);
    assign c_op    = is_op(in);
    assign c_plus  = (in == CH_PLUS);
    // For '0'..'9' the low nibble is exactly the digit value.
    assign dval    = W'(in[3:0]);

    assign rpar_full = (W+1)'(i_sum) + (W+1)'(i_prod);
    assign res_full  = (W+1)'(o_sum_nxt) + (W+1)'(o_prod_nxt);

    // Next-state and accumulator control decode.
    always_comb begin
        nxt      = state;
        o_opnd   = 1'b0;
        o_plus   = 1'b0;
        i_init   = 1'b0;
        i_opnd   = 1'b0;
        i_plus   = 1'b0;
        o_val    = dval;
        dig_app  = 1'b0;
        rpar_app = 1'b0;
        if (in_valid) begin
            case (state)
                S_START, S_OPER: begin
                    if (c_digit) begin
                        nxt     = S_OPND;
                        o_opnd  = 1'b1;
                        dig_app = 1'b1;
                    end else if (in == CH_LPAR) begin
                        nxt    = S_LPAR;
                        i_init = 1'b1;
                    end else begin
                        nxt = S_ERR;
                    end
                end
                S_OPND: begin
                    if (c_op) begin
                        nxt    = S_OPER;
                        o_plus = c_plus;
                    end else begin
                        nxt = S_ERR;
                    end
                end
                S_LPAR, S_IN_OPER: begin
                    // Empty "()" and nested '(' both land in S_ERR here.
                    if (c_digit) begin
                        nxt     = S_IN_OPND;
                        i_opnd  = 1'b1;
                        dig_app = 1'b1;
                    end else begin
                        nxt = S_ERR;
                    end
                end
                S_IN_OPND: begin
                    if (c_op) begin
                        nxt    = S_IN_OPER;
                        i_plus = c_plus;
                    end else if (in == CH_RPAR) begin
                        nxt      = S_OPND;
                        o_opnd   = 1'b1;
                        o_val    = rpar_full[W-1:0];
                        rpar_app = 1'b1;
                    end else begin
                        nxt = S_ERR;
                    end
                end
                default: nxt = S_ERR;
            endcase
        end
    end

    expr_acc #(.W(W)) u_outer (
        .clk      (clk),
        .clr_n    (clr_n),
        .init     (1'b0),
        .opnd     (o_opnd),
        .val      (o_val),
        .plus     (o_plus),
        .sum      (o_sum),
        .prod     (o_prod),
        .sum_nxt  (o_sum_nxt),
        .prod_nxt (o_prod_nxt),
        .ovf      (o_ovf)
    );

    expr_acc #(.W(W)) u_inner (
        .clk      (clk),
        .clr_n    (clr_n),
        .init     (i_init),
        .opnd     (i_opnd),
        .val      (dval),
        .plus     (i_plus),
        .sum      (i_sum),
        .prod     (i_prod),
        .sum_nxt  (i_sum_nxt),
        .prod_nxt (i_prod_nxt),
        .ovf      (i_ovf)
    );

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state        <= S_START;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else if (in_valid) begin
            state <= nxt;
            if (nxt == S_OPND) begin
                result       <= res_full[W-1:0];
                result_valid <= 1'b1;
            end else if (nxt == S_ERR) begin
                result       <= '0;
                result_valid <= 1'b0;
                err          <= 1'b1;
            end else begin
                // result keeps the last complete prefix value
                result_valid <= 1'b0;
            end
        end
    end

    // The inner next-state values are consumed inside the accumulator only.
    logic acc_unused;
    assign acc_unused = ^{i_sum_nxt, i_prod_nxt};

`ifdef EXPR_EVAL_OVF_EN
    localparam logic NARROW = (W < 4);

    logic ovf_q;
    logic ovf_evt;

    assign ovf_evt = o_ovf | i_ovf | (dig_app & NARROW) |
                     (rpar_app & rpar_full[W]) |
                     ((nxt == S_OPND) & res_full[W]);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ovf_q <= 1'b0;
        end else if (in_valid && ovf_evt) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    logic ovf_unused;
    assign ovf_unused = o_ovf | i_ovf | dig_app | rpar_app | rpar_full[W] | res_full[W];
    assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_expr_eval.sv
// Directed testbench for expr_eval: a W=16 instance for the main scenarios and
// a W=8 instance sharing the same inputs for the wrap-around scenario.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_expr_eval;

    logic        clk;
    logic        clr_n;
    logic [7:0]  ch;
    logic        vld;

    logic [15:0] res16;
    logic        rv16, err16, ovf16;
    logic [7:0]  res8;
    logic        rv8, err8, ovf8;

    int errors = 0;
    int checks = 0;

`ifdef EXPR_EVAL_OVF_EN
    localparam logic OVF8_EXP = 1'b1;
`else
    localparam logic OVF8_EXP = 1'b0;
`endif

    expr_eval #(.W(16)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .in           (ch),
        .in_valid     (vld),
        .result       (res16),
        .result_valid (rv16),
        .err          (err16),
        .ovf          (ovf16)
    );

    expr_eval #(.W(8)) dut8 (
        .clk          (clk),
        .clr_n        (clr_n),
        .in           (ch),
        .in_valid     (vld),
        .result       (res8),
        .result_valid (rv8),
        .err          (err8),
        .ovf          (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input byte c);
        @(negedge clk);
        ch  = c;
        vld = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        vld = 1'b0;
        #1 clr_n = 1'b0;
        #2 clr_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        vld   = 1'b0;
        ch    = 8'h00;
        #7;
        checks++; if (res16 !== 16'd0) begin errors++; $display("FAIL reset_result got=%0d want=0", res16); end
        checks++; if (rv16 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", rv16); end
        #5 clr_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (res16 !== 16'd0) begin errors++; $display("FAIL post_reset_result got=%0d want=0", res16); end
        checks++; if (rv16 !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b want=0", rv16); end
        checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err16); end
        checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf16); end
        checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL reset_ovf_w8 got=%b want=0", ovf8); end
    endtask

    task automatic test_precedence();
        string s = "1+2*3";
        logic        ev[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] er[5] = '{16'd1, 16'd1, 16'd3, 16'd3, 16'd7};
        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            send(s[i]);
            checks++; if (rv16 !== ev[i]) begin errors++; $display("FAIL prec_valid[%0d] got=%b want=%b", i, rv16, ev[i]); end
            checks++; if (res16 !== er[i]) begin errors++; $display("FAIL prec_result[%0d] got=%0d want=%0d", i, res16, er[i]); end
        end
    endtask

    task automatic test_paren();
        string s = "(2+3)*4";
        logic        ev[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] er[7] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'd5, 16'd20};
        pulse_clr();
        for (int i = 0; i < 7; i++) begin
            send(s[i]);
            checks++; if (rv16 !== ev[i]) begin errors++; $display("FAIL paren_valid[%0d] got=%b want=%b", i, rv16, ev[i]); end
            checks++; if (res16 !== er[i]) begin errors++; $display("FAIL paren_result[%0d] got=%0d want=%0d", i, res16, er[i]); end
        end
    endtask

    task automatic test_nested_expr();
        string s = "2*(1+1*3)+5";
        pulse_clr();
        for (int i = 0; i < s.len(); i++) send(s[i]);
        checks++; if (res16 !== 16'd13) begin errors++; $display("FAIL mixed_result got=%0d want=13", res16); end
        checks++; if (rv16 !== 1'b1) begin errors++; $display("FAIL mixed_valid got=%b want=1", rv16); end
        checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL mixed_err got=%b want=0", err16); end
    endtask

    task automatic test_error();
        pulse_clr();
        send("1");
        send("+");
        checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL err_early got=%b want=0", err16); end
        send("+");
        checks++; if (err16 !== 1'b1) begin errors++; $display("FAIL err_rise got=%b want=1", err16); end
        checks++; if (res16 !== 16'd0) begin errors++; $display("FAIL err_result got=%0d want=0", res16); end
        checks++; if (rv16 !== 1'b0) begin errors++; $display("FAIL err_valid got=%b want=0", rv16); end
        send("5");
        checks++; if (rv16 !== 1'b0) begin errors++; $display("FAIL err_absorb_valid got=%b want=0", rv16); end
        checks++; if (res16 !== 16'd0) begin errors++; $display("FAIL err_absorb_result got=%0d want=0", res16); end
        checks++; if (err16 !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", err16); end
        pulse_clr();
        #1;
        checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL err_clr got=%b want=0", err16); end
        send("4");
        checks++; if (res16 !== 16'd4) begin errors++; $display("FAIL err_restart_result got=%0d want=4", res16); end
        checks++; if (rv16 !== 1'b1) begin errors++; $display("FAIL err_restart_valid got=%b want=1", rv16); end
    endtask

    task automatic test_idle_hold();
        pulse_clr();
        send("9");
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            checks++; if (res16 !== 16'd9) begin errors++; $display("FAIL idle_result[%0d] got=%0d want=9", i, res16); end
            checks++; if (rv16 !== 1'b1) begin errors++; $display("FAIL idle_valid[%0d] got=%b want=1", i, rv16); end
        end
        send("*");
        checks++; if (rv16 !== 1'b0) begin errors++; $display("FAIL idle_op_valid got=%b want=0", rv16); end
        checks++; if (res16 !== 16'd9) begin errors++; $display("FAIL idle_op_result got=%0d want=9", res16); end
        send("9");
        checks++; if (res16 !== 16'd81) begin errors++; $display("FAIL idle_final_result got=%0d want=81", res16); end
        checks++; if (rv16 !== 1'b1) begin errors++; $display("FAIL idle_final_valid got=%b want=1", rv16); end
    endtask

    task automatic test_async_clr();
        pulse_clr();
        send("9");
        send("*");
        send("(");
        checks++; if (res16 !== 16'd9) begin errors++; $display("FAIL aclr_pre_result got=%0d want=9", res16); end
        // Assert reset mid-cycle, away from any clock edge, with in_valid still high.
        #2 clr_n = 1'b0;
        #1;
        checks++; if (res16 !== 16'd0) begin errors++; $display("FAIL aclr_result got=%0d want=0", res16); end
        checks++; if (rv16 !== 1'b0) begin errors++; $display("FAIL aclr_valid got=%b want=0", rv16); end
        checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL aclr_err got=%b want=0", err16); end
        @(negedge clk);
        vld = 1'b0;
        #1 clr_n = 1'b1;
        send("3");
        checks++; if (res16 !== 16'd3) begin errors++; $display("FAIL aclr_restart_result got=%0d want=3", res16); end
        checks++; if (rv16 !== 1'b1) begin errors++; $display("FAIL aclr_restart_valid got=%b want=1", rv16); end
    endtask

    task automatic test_wrap();
        string s = "9*9*9";
        pulse_clr();
        for (int i = 0; i < 5; i++) send(s[i]);
        checks++; if (res8 !== 8'd217) begin errors++; $display("FAIL wrap_w8_result got=%0d want=217", res8); end
        checks++; if (rv8 !== 1'b1) begin errors++; $display("FAIL wrap_w8_valid got=%b want=1", rv8); end
        checks++; if (ovf8 !== OVF8_EXP) begin errors++; $display("FAIL wrap_w8_ovf got=%b want=%b", ovf8, OVF8_EXP); end
        checks++; if (res16 !== 16'd729) begin errors++; $display("FAIL wrap_w16_result got=%0d want=729", res16); end
        checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL wrap_w16_ovf got=%b want=0", ovf16); end
    endtask

    initial begin
        test_reset();
        test_precedence();
        test_paren();
        test_nested_expr();
        test_error();
        test_idle_hold();
        test_async_clr();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/expr_eval.md
# expr_eval

Downstream companion to the expression recognizer: consumes the same ASCII character stream, one character per accepted cycle, and computes the integer value of the expression prefix whenever that prefix is a complete, valid expression. Grammar:

- term = digit | '(' digit (op digit)* ')'
- expr = term (op term)*
- op = '+' | '*'
- '*' binds tighter than '+'.
- Parentheses nest one level only.

Its `result_valid` matches the recognizer's accept output cycle-for-cycle, so the two sit side by side on the character bus.

## Interface
- W, 16, datapath width of all accumulators and `result`.
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- in  in  8  ASCII character.
- in_valid  in  1  character on `in` is consumed this cycle.
- result  out  W  value of the current complete prefix.
- result_valid  out  1  current prefix is a complete valid expression.
- err  out  1  sticky: stream left the grammar.
- ovf  out  1  sticky arithmetic overflow (see Configuration).

## Operation
- Digit value = `in` - 48, zero-extended to W. Digits are ASCII 48..57.
- Outer accumulator holds `sum_o` and `prod_o`. Inner accumulator (inside parentheses) holds `sum_i` and `prod_i`.
- Accumulator rules:
  - Init: sum=0, prod=1.
  - Operand v: prod <= prod*v.
  - '+': sum <= sum+prod, then prod <= 1.
  - '*': no change.
- On '(': inner accumulator re-initialised.
- On ')': v = sum_i + prod_i is applied as an operand to the outer accumulator.
- Reported value = sum_o + prod_o, computed mod 2^W; products truncated to W bits.
- States and transitions (any unlisted character goes to S_ERR):
  - S_START: digit -> S_OPND; '(' -> S_LPAR.
  - S_OPND: op -> S_OPER.
  - S_OPER: digit -> S_OPND; '(' -> S_LPAR.
  - S_LPAR: digit -> S_IN_OPND.
  - S_IN_OPND: op -> S_IN_OPER; ')' -> S_OPND.
  - S_IN_OPER: digit -> S_IN_OPND.
- S_ERR is absorbing. Only `clr_n` leaves it.
- A nested '(' or an empty "()" goes to S_ERR.
- `in_valid` low: state, accumulators and all outputs hold.

## Timing
- Reset values: state=S_START, accumulators at init, result=0, result_valid=0, err=0, ovf=0.
- All outputs are registered. Latency is one cycle: a character accepted at edge n is reflected in the outputs after edge n.
- `result_valid` is 1 exactly when the next state is S_OPND. In that cycle `result` = new sum_o + new prod_o.
- When `result_valid` is 0, `result` holds its last valid value.
- On entry to S_ERR:
  - `err` rises on the same edge.
  - `result` clears to 0.
  - `result_valid` is 0 from then on.
- `clr_n` asserted mid-expression clears everything asynchronously, regardless of `clk` or `in_valid`. The first character after release is treated as the start of a new stream.
- There is no back-pressure; every character with `in_valid` high is consumed.

## Configuration
- EXPR_EVAL_OVF_EN defined:
  - `ovf` is set when any add or multiply result exceeds W bits, or when a digit is applied with W < 4.
  - `ovf` is sticky until reset.
  - Arithmetic still wraps.
- EXPR_EVAL_OVF_EN undefined:
  - Overflow logic is not built.
  - `ovf` is tied to 0.

## Structure
- Shared package `expr_pkg` contains:
  - the state enum (S_START, S_OPND, S_OPER, S_LPAR, S_IN_OPND, S_IN_OPER, S_ERR);
  - ASCII constants for '0', '9', '+', '*', '(', ')';
  - the `is_digit` and `is_op` helper functions.
- Sub-module `expr_acc`:
  - one sum/product accumulator, parameterised by W;
  - controls: init, operand (value), plus;
  - outputs: sum, prod, and an overflow flag;
  - instantiated twice in `expr_eval`, once for the outer level and once for the inner level.
- Top level contains the FSM, operand select and output registers.

## Test plan
- "1+2*3" streamed with `in_valid` held high:
  - `result_valid` sequence: 1,0,1,0,1.
  - `result` when valid: 1, 3, 7.
- "(2+3)*4":
  - `result_valid` is 0 for the first 4 characters.
  - `result` is 5 after ')' and 20 after '4'.
- "2*(1+1*3)+5": final `result`=13 with `result_valid`=1; no `err`.
- "1++5":
  - `err` rises after the second '+'.
  - `result` becomes 0 and `result_valid` stays 0 through '5'.
  - After a `clr_n` pulse, "4" gives `result`=4.
- "9", 3 idle cycles (`in_valid`=0), then "*9":
  - Outputs hold `result`=9 and `result_valid`=1 during the idle cycles.
  - Final `result`=81.
  - Separately: `clr_n` asserted between '(' and '3' clears all outputs within the same cycle.
- W=8, "9*9*9":
  - `result`=217 (729 mod 256).
  - `ovf`=1 with EXPR_EVAL_OVF_EN defined; `ovf`=0 without it.
